data_mem_controller: RTL and testbench

DATA_MEM_CONTROLLER -- requirements
Module: data_mem_controller

---
 rtl/rv32im_mem_pkg.sv | 69 ++++++
 rtl/load_formatter.sv | 29 ++
 rtl/data_mem_controller.sv | 140 ++++++++++++++
 tb/tb_data_mem_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32im_mem_pkg.sv
// Shared memory-access definitions for the RV32IM core: load/store funct3
// codes, MEM_READ/MEM_WRITE field positions, controller FSM encoding and
// small size/alignment helpers.
package rv32im_mem_pkg;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3[1:0] codes
  localparam logic [1:0] F3_SB = 2'b00;
  localparam logic [1:0] F3_SH = 2'b01;
  localparam logic [1:0] F3_SW = 2'b10;

  // Enable bit positions within the control-unit memory fields
  localparam int MEM_READ_EN_BIT  = 3;
  localparam int MEM_WRITE_EN_BIT = 2;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Loads and stores share the low two funct3 bits for access size;
  // the undefined encodings fall back to a full word.
  function automatic mem_size_e mem_size(input logic [1:0] f3_lo);
    case (f3_lo)
      F3_SB:   return SZ_BYTE;
      F3_SH:   return SZ_HALF;
      F3_SW:   return SZ_WORD;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b0;
    endcase
  endfunction

  // Clears the low offset bits that a naturally aligned access cannot use
  function automatic logic [1:0] align_off(input mem_size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return {off[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return off;
    endcase
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Load data extraction: selects the byte/half addressed within the fetched
// word and sign- or zero-extends it according to the load funct3.
module load_formatter
  import rv32im_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  output logic [31:0] result_o
);

  logic [7:0]  b;
  logic [15:0] h;

  // Lane select then extend; undefined codes read as a full word
  always_comb begin
    b = word_i[{addr_i, 3'b000} +: 8];
    h = addr_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_LB:   result_o = {{24{b[7]}}, b};
      F3_LH:   result_o = {{16{h[15]}}, h};
      F3_LBU:  result_o = {24'b0, b};
      F3_LHU:  result_o = {16'b0, h};
      F3_LW:   result_o = word_i;
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_mem_controller.sv
// Data memory controller: turns one pipeline load/store into a
// IDLE -> ACCESS -> DONE handshake with the backing word memory, stalling
// the pipeline through BUSYWAIT. Define DMEM_MISALIGN_TRAP_EN to flag
// misaligned half/word requests on MISALIGNED instead of silently aligning.
module data_mem_controller
  import rv32im_mem_pkg::*;
#(
  parameter int DMEM_ADDR_W = 30
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [3:0]             MEM_READ,
  input  logic [2:0]             MEM_WRITE,
  input  logic [31:0]            ADDRESS,
  input  logic [31:0]            WRITE_DATA,
  output logic [31:0]            READ_DATA,
  output logic                   BUSYWAIT,
  output logic                   MISALIGNED,
  output logic                   DMEM_READ,
  output logic                   DMEM_WRITE,
  output logic [DMEM_ADDR_W-1:0] DMEM_ADDR,
  output logic [31:0]            DMEM_WDATA,
  output logic [3:0]             DMEM_BYTE_EN,
  input  logic [31:0]            DMEM_RDATA,
  input  logic                   DMEM_BUSYWAIT
);

  mem_state_e  state_q, state_d;
  mem_req_t    req_q, req_d;
  logic [31:0] rdata_q;
  logic [31:0] fmt_data;
  logic [3:0]  st_be;
  logic        is_store, is_load, req_vld, start;
  mem_size_e   req_sz, acc_sz;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        misal;
`endif

  // Decode the incoming request (store wins) and build the aligned copy to latch
  always_comb begin
    is_store     = MEM_WRITE[MEM_WRITE_EN_BIT];
    is_load      = MEM_READ[MEM_READ_EN_BIT] & ~is_store;
    req_vld      = is_store | is_load;
    req_d.store  = is_store;
    req_d.funct3 = is_store ? {1'b0, MEM_WRITE[1:0]} : MEM_READ[2:0];
    req_sz       = mem_size(req_d.funct3[1:0]);
    req_d.addr   = {ADDRESS[31:2], align_off(req_sz, ADDRESS[1:0])};
    req_d.wdata  = WRITE_DATA;
`ifdef DMEM_MISALIGN_TRAP_EN
    misal        = req_vld & is_misaligned(req_sz, ADDRESS[1:0]);
    start        = req_vld & ~misal;
`else
    start        = req_vld;
`endif
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= MEM_IDLE;
    else       state_q <= state_d;
  end

  // Request latch, captured only when a transaction starts
  always_ff @(posedge CLK) begin
    if (RESET)                              req_q <= '0;
    else if (state_q == MEM_IDLE && start)  req_q <= req_d;
  end

  load_formatter u_fmt (
    .word_i   (DMEM_RDATA),
    .funct3_i (req_q.funct3),
    .addr_i   (req_q.addr[1:0]),
    .result_o (fmt_data)
  );

  // Load result register, updated on the edge the memory completes a load
  always_ff @(posedge CLK) begin
    if (RESET)
      rdata_q <= '0;
    else if (state_q == MEM_ACCESS && !DMEM_BUSYWAIT && !req_q.store)
      rdata_q <= fmt_data;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE:   if (start) state_d = MEM_ACCESS;
      MEM_ACCESS: if (!DMEM_BUSYWAIT) state_d = MEM_DONE;
      MEM_DONE:   state_d = MEM_IDLE;
      default:    state_d = MEM_IDLE;
    endcase
  end

  // Store lane enables and replicated write data from the latched request
  always_comb begin
    acc_sz     = mem_size(req_q.funct3[1:0]);
    st_be      = 4'b1111;
    DMEM_WDATA = req_q.wdata;
    case (acc_sz)
      SZ_BYTE: begin
        st_be      = 4'b0001 << req_q.addr[1:0];
        DMEM_WDATA = {4{req_q.wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be      = 4'b0011 << {req_q.addr[1], 1'b0};
        DMEM_WDATA = {2{req_q.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // FSM outputs: stall while starting/accessing, strobes only in ACCESS
  always_comb begin
    BUSYWAIT     = 1'b0;
    DMEM_READ    = 1'b0;
    DMEM_WRITE   = 1'b0;
    DMEM_BYTE_EN = 4'b0000;
    case (state_q)
      MEM_IDLE:   BUSYWAIT = start;
      MEM_ACCESS: begin
        BUSYWAIT     = 1'b1;
        DMEM_READ    = ~req_q.store;
        DMEM_WRITE   = req_q.store;
        DMEM_BYTE_EN = req_q.store ? st_be : 4'b1111;
      end
      default: ;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign MISALIGNED = (state_q == MEM_IDLE) & misal;
`else
  assign MISALIGNED = 1'b0;
`endif

  assign DMEM_ADDR = req_q.addr[DMEM_ADDR_W+1:2];
  assign READ_DATA = rdata_q;

endmodule

// File: tb/tb_data_mem_controller.sv
// Self-checking bench for data_mem_controller: directed scenarios followed by
// randomized loads/stores checked against a size/offset arithmetic model.
module tb_data_mem_controller;

  localparam int AW = 30;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [3:0]    MEM_READ;
  logic [2:0]    MEM_WRITE;
  logic [31:0]   ADDRESS, WRITE_DATA, READ_DATA;
  logic          BUSYWAIT, MISALIGNED, DMEM_READ, DMEM_WRITE;
  logic [AW-1:0] DMEM_ADDR;
  logic [31:0]   DMEM_WDATA;
  logic [3:0]    DMEM_BYTE_EN;
  logic [31:0]   DMEM_RDATA;
  logic          DMEM_BUSYWAIT;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_rd = 32'h0;

  always #5 CLK = ~CLK;

  data_mem_controller #(.DMEM_ADDR_W(AW)) dut (
    .CLK(CLK), .RESET(RESET),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
    .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT), .MISALIGNED(MISALIGNED),
    .DMEM_READ(DMEM_READ), .DMEM_WRITE(DMEM_WRITE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_BYTE_EN(DMEM_BYTE_EN),
    .DMEM_RDATA(DMEM_RDATA), .DMEM_BUSYWAIT(DMEM_BUSYWAIT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // ---- reference model: access size in bytes, and load result arithmetic
  function automatic int unsigned nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] sh, b, h;
    sh = rd >> (8 * (a % 4));
    b  = sh % 256;
    h  = sh % 65536;
    case (f3)
      3'b000:  return (b >= 128)   ? b - 256   : b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rd;
    endcase
  endfunction

  // Runs one request to completion starting in IDLE; checks stall length,
  // strobes, lanes, address and the load result against the model.
  task automatic run_op(input string tag, input bit st, input bit both, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int nbusy);
    int          stall, acc, bad, cyc;
    logic [31:0] a, cap_addr, cap_be, cap_wd, exp_be, exp_wd;
    int unsigned n;
    stall = 0; acc = 0; bad = 0; cyc = 0;
    cap_addr = '1; cap_be = '1; cap_wd = '1;
    n = nbytes(f3);
    a = addr - (addr % n);
    if (st) begin
      MEM_WRITE = {1'b1, f3[1:0]};
      MEM_READ  = {both, 3'($urandom)};
    end else begin
      MEM_WRITE = {1'b0, 2'($urandom)};
      MEM_READ  = {1'b1, f3};
    end
    ADDRESS = addr; WRITE_DATA = wd; DMEM_RDATA = rd;
    DMEM_BUSYWAIT = (nbusy > 0);
    forever begin
      @(negedge CLK);
      cyc++;
      if (MISALIGNED !== 1'b0) bad++;
      if (BUSYWAIT !== 1'b1) break;
      stall++;
      if (DMEM_READ === 1'b1 || DMEM_WRITE === 1'b1) begin
        acc++;
        if (DMEM_WRITE !== st || DMEM_READ !== !st) bad++;
        cap_addr = 32'(DMEM_ADDR);
        cap_be   = 32'(DMEM_BYTE_EN);
        cap_wd   = DMEM_WDATA;
        DMEM_BUSYWAIT = (acc <= nbusy);
      end
      if (cyc > 40) break;
    end
    chk({tag, ":stall"}, stall, nbusy + 2);
    chk({tag, ":access"}, acc, nbusy + 1);
    chk({tag, ":strobe_kind"}, bad, 0);
    chk({tag, ":addr"}, cap_addr, addr >> 2);
    if (st) begin
      exp_be = (n == 1) ? (32'd1 << (a % 4)) : (n == 2) ? (32'd3 << (a % 4)) : 32'd15;
      exp_wd = (n == 1) ? wd[7:0] * 32'h01010101 : (n == 2) ? wd[15:0] * 32'h00010001 : wd;
      chk({tag, ":byte_en"}, cap_be, exp_be);
      chk({tag, ":wdata"}, cap_wd, exp_wd);
    end else begin
      chk({tag, ":byte_en"}, cap_be, 32'd15);
      exp_rd = load_val(f3, a, rd);
    end
    chk({tag, ":read_data"}, READ_DATA, exp_rd);
    chk({tag, ":done_quiet"}, {28'b0, DMEM_READ, DMEM_WRITE, |DMEM_BYTE_EN, BUSYWAIT}, 32'd0);
    @(posedge CLK); #1;
    MEM_READ = '0; MEM_WRITE = '0; DMEM_BUSYWAIT = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          st, both;
    logic [2:0]  f3;
    logic [31:0] addr;

    RESET = 1'b1; MEM_READ = '0; MEM_WRITE = '0; ADDRESS = '0; WRITE_DATA = '0;
    DMEM_RDATA = '0; DMEM_BUSYWAIT = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset:read_data", READ_DATA, 32'h0);
    chk("reset:busywait", 32'(BUSYWAIT), 32'h0);
    chk("reset:misaligned", 32'(MISALIGNED), 32'h0);
    chk("reset:strobes", {30'b0, DMEM_READ, DMEM_WRITE}, 32'h0);
    chk("reset:byte_en", 32'(DMEM_BYTE_EN), 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // LW, no memory wait
    run_op("lw100", 1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    chk("lw100:value", READ_DATA, 32'hDEADBEEF);

    // LB / LBU of the top byte
    run_op("lb103", 1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0);
    chk("lb103:value", READ_DATA, 32'hFFFFFF80);
    run_op("lbu103", 1'b0, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0);
    chk("lbu103:value", READ_DATA, 32'h00000080);

    // SH to upper half; READ_DATA must keep the last load
    run_op("sh102", 1'b1, 1'b0, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 0);
    chk("sh102:hold", READ_DATA, 32'h00000080);

    // LW with a slow memory
    run_op("lw_wait3", 1'b0, 1'b0, 3'b010, 32'h2C, 32'h0, 32'h13579BDF, 3);

    // load and store both requested: store wins
    run_op("both_sb", 1'b1, 1'b1, 3'b000, 32'h1F1, 32'h000000A5, 32'h0, 1);

    // reset during the second ACCESS cycle of an SW
    MEM_READ = '0; MEM_WRITE = 3'b110; ADDRESS = 32'h200; WRITE_DATA = 32'h12345678;
    DMEM_BUSYWAIT = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rst_mid:write_in_access", 32'(DMEM_WRITE), 32'h1);
    @(posedge CLK); #1;
    RESET = 1'b1; MEM_WRITE = '0;
    @(posedge CLK); #1;
    RESET = 1'b0; DMEM_BUSYWAIT = 1'b0;
    @(negedge CLK);
    chk("rst_mid:write", 32'(DMEM_WRITE), 32'h0);
    chk("rst_mid:busywait", 32'(BUSYWAIT), 32'h0);
    chk("rst_mid:read_data", READ_DATA, 32'h0);
    exp_rd = 32'h0;
    @(posedge CLK); #1;
    run_op("after_rst", 1'b0, 1'b0, 3'b101, 32'h32, 32'h0, 32'hF00DBEEF, 0);

    // misaligned word load
`ifdef DMEM_MISALIGN_TRAP_EN
    MEM_READ = 4'b1010; MEM_WRITE = '0; ADDRESS = 32'h101; DMEM_RDATA = 32'hCAFEF00D;
    @(negedge CLK);
    chk("mis:flag", 32'(MISALIGNED), 32'h1);
    chk("mis:busywait", 32'(BUSYWAIT), 32'h0);
    chk("mis:strobe", {30'b0, DMEM_READ, DMEM_WRITE}, 32'h0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("mis:strobe_next", {30'b0, DMEM_READ, DMEM_WRITE}, 32'h0);
    chk("mis:read_data", READ_DATA, exp_rd);
    @(posedge CLK); #1;
    MEM_READ = '0;
`else
    run_op("mis_lw101", 1'b0, 1'b0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 0);
`endif

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      st   = 1'($urandom);
      both = 1'($urandom);
      f3   = st ? {1'b0, 2'($urandom)} : 3'($urandom);
      addr = $urandom;
`ifdef DMEM_MISALIGN_TRAP_EN
      addr = addr - (addr % nbytes(f3));
`endif
      run_op($sformatf("rnd%0d", i), st, both, f3, addr, $urandom, $urandom,
             int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
